// File: rtl/merge.sv
// merge -- N-to-1 native-bus merger.
//
// Several native-bus masters share one slave port. A registered arbiter picks
// one requesting master while IDLE, then passes that master's request straight
// through to the slave and routes the slave response straight back to it until
// the slave's ready. The FSM returns to IDLE after every transaction, so the
// slave sees exactly one valid per granted transaction.
//
// Ports:
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   m_req   in   N_MASTERS request slices, master i at slice i,
//                each {valid, addr[ADDR_W], wdata[32], wstrb[4]}
//   m_resp  out  N_MASTERS response slices, each {rdata[32], ready}
//   s_req   out  request to the shared slave (same layout as one m_req slice)
//   s_resp  in   response from the shared slave ({rdata[32], ready})
//
// Build option:
//   MERGE_RR_EN defined   -> round-robin arbitration starting after the last
//                            completed grant (last-grant register present)
//   MERGE_RR_EN undefined -> fixed priority, lowest master index wins
module merge #(
   parameter int N_MASTERS   = 2,
   parameter int ADDR_W      = 32,
   parameter int N_MASTERS_W = $clog2(N_MASTERS)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [N_MASTERS*(ADDR_W+37)-1:0] m_req,
   output logic [N_MASTERS*33-1:0]          m_resp,
   output logic [ADDR_W+36:0]               s_req,
   input  logic [32:0]                      s_resp
);
   localparam int REQ_W  = ADDR_W + 37;
   localparam int RESP_W = 33;

   typedef enum logic [0:0] { IDLE = 1'b0, BUSY = 1'b1 } state_t;

   state_t                 state_r;
   state_t                 state_nx_s;
   logic [N_MASTERS_W-1:0] grant_r;
   logic [N_MASTERS_W-1:0] grant_nx_s;
   logic [N_MASTERS_W-1:0] winner_s;
   logic [N_MASTERS-1:0]   valid_s;
   logic                   any_valid_s;
   logic                   ready_s;
   logic [REQ_W-1:0]       granted_req_s;
`ifdef MERGE_RR_EN
   logic [N_MASTERS_W-1:0] last_r;
   logic [N_MASTERS_W-1:0] last_nx_s;
`endif

   assign ready_s     = s_resp[0];
   assign any_valid_s = |valid_s;

`ifdef MERGE_RR_EN
   // First requester found scanning upward from last+1, wrapping at N_MASTERS.
   function automatic logic [N_MASTERS_W-1:0] rr_pick(input logic [N_MASTERS-1:0]   v,
                                                      input logic [N_MASTERS_W-1:0] last);
      logic [N_MASTERS_W-1:0] pick;
      logic                   found;
      logic                   hit;
      int                     idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         idx   = (int'(last) + k) % N_MASTERS;
         hit   = v[idx] & ~found;
         pick  = hit ? N_MASTERS_W'(idx) : pick;
         found = found | hit;
      end
      return pick;
   endfunction
`else
   // Lowest-index requester; scanning downward lets the lowest index overwrite.
   function automatic logic [N_MASTERS_W-1:0] fixed_pick(input logic [N_MASTERS-1:0] v);
      logic [N_MASTERS_W-1:0] pick;
      pick = '0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         pick = v[i] ? N_MASTERS_W'(i) : pick;
      end
      return pick;
   endfunction
`endif

   // Extract per-master valid bits and select the granted master's request.
   always_comb begin
      valid_s       = '0;
      granted_req_s = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         valid_s[i]    = m_req[i*REQ_W + REQ_W - 1];
         granted_req_s = (grant_r == N_MASTERS_W'(i)) ? m_req[i*REQ_W +: REQ_W] : granted_req_s;
      end
   end

   // Arbitration winner, only consumed in IDLE.
   always_comb begin
`ifdef MERGE_RR_EN
      winner_s = rr_pick(valid_s, last_r);
`else
      winner_s = fixed_pick(valid_s);
`endif
   end

   // Next-state logic: grant in IDLE, release on ready or on a dropped valid.
   always_comb begin
      state_nx_s = state_r;
      grant_nx_s = grant_r;
`ifdef MERGE_RR_EN
      last_nx_s  = last_r;
`endif
      case (state_r)
         IDLE: begin
            if (any_valid_s) begin
               state_nx_s = BUSY;
               grant_nx_s = winner_s;
            end else begin
               state_nx_s = IDLE;
            end
         end
         BUSY: begin
            if (ready_s) begin
               // Completed transaction: it becomes the round-robin reference.
               state_nx_s = IDLE;
`ifdef MERGE_RR_EN
               last_nx_s  = grant_r;
`endif
            end else if (!granted_req_s[REQ_W-1]) begin
               // Master abandoned its request; nothing delivered, history kept.
               state_nx_s = IDLE;
            end else begin
               state_nx_s = BUSY;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State, grant and (round-robin) last-grant registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         grant_r <= '0;
`ifdef MERGE_RR_EN
         last_r  <= N_MASTERS_W'(N_MASTERS - 1);
`endif
      end else begin
         state_r <= state_nx_s;
         grant_r <= grant_nx_s;
`ifdef MERGE_RR_EN
         last_r  <= last_nx_s;
`endif
      end
   end

   // Output routing: depends on m_req only through s_req, never into m_resp.
   always_comb begin
      s_req  = '0;
      m_resp = '0;
      if (state_r == BUSY) begin
         s_req = granted_req_s;
         for (int i = 0; i < N_MASTERS; i++) begin
            m_resp[i*RESP_W +: RESP_W] = (grant_r == N_MASTERS_W'(i)) ? s_resp : {RESP_W{1'b0}};
         end
      end else begin
         s_req  = '0;
         m_resp = '0;
      end
   end

endmodule
